// File: rtl/fb_frame_pkg.sv
// Shared mode codes and FSM encoding for the feedback LED frame receiver.
// Kept separate so UART-side tooling and other decoders can reuse the codes.
package fb_frame_pkg;

    localparam logic [1:0] MODE_SCRIPT   = 2'b00;
    localparam logic [1:0] MODE_UNSCRIPT = 2'b01;
    localparam logic [1:0] MODE_EXT      = 2'b10;
    localparam logic [1:0] MODE_RSVD     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PAYLOAD = 2'b01,
        ST_CHECK   = 2'b10
    } fb_state_t;

endpackage

// File: rtl/valid_edge_sync.sv
// Two-flop synchroniser for an asynchronous level followed by a rising-edge
// detector; a level held high for any length yields a single one-cycle pulse.
module valid_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse_out
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= async_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign pulse_out = sync2_reg & ~prev_reg;

endmodule

// File: rtl/feedback_frame_rx.sv
// Decodes UART bytes into feedback LED updates: single-byte script/unscripted
// commands or checksummed multi-byte extended frames with an inter-byte timeout.
module feedback_frame_rx
    import fb_frame_pkg::*;
#(
    parameter int LED_W         = 4,
    parameter int PAYLOAD_BYTES = (LED_W + 7) / 8,
    parameter int TIMEOUT_CYC   = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_valid,
    input  logic [7:0]       data_receive,
    output logic [LED_W-1:0] feedback_leds,
    output logic [1:0]       mode,
    output logic             frame_done,
    output logic             frame_err,
    output logic             busy
);

    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    fb_state_t         state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [7:0]        csum_reg, csum_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [LED_W-1:0]  shadow_reg, shadow_next;
    logic [LED_W-1:0]  leds_reg, leds_next;
    logic [1:0]        mode_reg, mode_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              shadow_we;
    logic              byte_stb;
    logic              tmo_expired;
    logic [LED_W-1:0]  single_leds;

    valid_edge_sync u_valid_sync (
        .clk       (clk),
        .rst       (rst),
        .async_in  (data_valid),
        .pulse_out (byte_stb)
    );

    // Only LED bits that exist are stored; payload bits above LED_W are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < LED_W; gi++) begin : g_led_bit
            if (gi < 4) begin : g_lo
                assign single_leds[gi] = data_receive[gi + 2];
            end else begin : g_hi
                assign single_leds[gi] = 1'b0;
            end
            assign shadow_next[gi] = (shadow_we && idx_reg == IDX_W'(gi / 8))
                                   ? data_receive[gi % 8] : shadow_reg[gi];
        end
    endgenerate

    // A strobe in the expiry cycle takes priority over the timeout.
    assign tmo_expired = !byte_stb && (tmo_reg == TMO_LAST);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        csum_next  = csum_reg;
        leds_next  = leds_reg;
        mode_next  = mode_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        shadow_we  = 1'b0;
        tmo_next   = (state_reg == ST_IDLE || byte_stb) ? '0 : tmo_reg + TMO_W'(1);

        case (state_reg)
            ST_IDLE: begin
                if (byte_stb) begin
                    case (data_receive[1:0])
                        MODE_SCRIPT: begin
                            leds_next = '0;
                            mode_next = MODE_SCRIPT;
                            done_next = 1'b1;
                        end
                        MODE_UNSCRIPT: begin
                            leds_next = single_leds;
                            mode_next = MODE_UNSCRIPT;
                            done_next = 1'b1;
                        end
                        MODE_EXT: begin
                            csum_next  = data_receive;
                            idx_next   = '0;
                            state_next = ST_PAYLOAD;
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end
            ST_PAYLOAD: begin
                if (byte_stb) begin
                    shadow_we = 1'b1;
                    csum_next = csum_reg ^ data_receive;
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = ST_CHECK;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end else if (tmo_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (byte_stb) begin
                    if (data_receive == csum_reg) begin
                        leds_next = shadow_reg;
                        mode_next = MODE_EXT;
                        done_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end else if (tmo_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            csum_reg   <= '0;
            tmo_reg    <= '0;
            shadow_reg <= '0;
            leds_reg   <= '0;
            mode_reg   <= MODE_SCRIPT;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            csum_reg   <= csum_next;
            tmo_reg    <= tmo_next;
            shadow_reg <= shadow_next;
            leds_reg   <= leds_next;
            mode_reg   <= mode_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    assign feedback_leds = leds_reg;
    assign mode          = mode_reg;
    assign frame_done    = done_reg;
    assign frame_err     = err_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule
